// File: rtl/fir_filter_param.sv
// Parametrised signed streaming direct-form FIR with runtime-writable coefficients,
// full-precision accumulation, round-half-up and saturation to the sample width.
module fir_filter_param #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 8,
  parameter int TAPS     = 4,
  parameter int FRAC     = 7,
  parameter int COEF_RST = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wr_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   data_out,
  output logic                       out_sat
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 1 - DATA_W){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 1 - DATA_W){1'b1}}, 1'b1, {(DATA_W - 1){1'b0}}};

  logic signed [COEF_W-1:0] r_coef [0:TAPS-1];
  logic signed [DATA_W-1:0] r_dly  [1:TAPS-1];
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_data_out;
  logic                     r_sat;

  logic signed [DATA_W-1:0] w_x    [0:TAPS-1];
  logic signed [PROD_W-1:0] w_prod [0:TAPS-1];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_r;
  logic signed [DATA_W-1:0] w_sat_data;
  logic                     w_sat;
  logic                     w_addr_ok;

  // Tap 0 is the live input so a sample is filtered in the cycle it arrives.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi == 0) begin : g_live
      assign w_x[gi] = data_in;
    end else begin : g_hist
      assign w_x[gi] = r_dly[gi];
    end
    assign w_prod[gi] = w_x[gi] * r_coef[gi];
  end

  if ((1 << AW) == TAPS) begin : g_addr_pow2
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_npow2
    assign w_addr_ok = (coef_addr < AW'(TAPS));
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + {{(ACC_W - PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
    end
  end

  // One guard bit keeps the rounding add from wrapping at the accumulator extreme.
  assign w_rnd = {w_acc[ACC_W-1], w_acc} + HALF;
  assign w_r   = w_rnd >>> FRAC;

  always_comb begin
    w_sat      = 1'b0;
    w_sat_data = w_r[DATA_W-1:0];
    if (w_r > MAXV) begin
      w_sat      = 1'b1;
      w_sat_data = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (w_r < MINV) begin
      w_sat      = 1'b1;
      w_sat_data = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= COEF_W'(COEF_RST);
      for (int k = 1; k < TAPS; k++) r_dly[k] <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (coef_wr_en && w_addr_ok) begin
        r_coef[coef_addr] <= coef_wr_data;
      end
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_dly[1] <= data_in;
        for (int k = 2; k < TAPS; k++) r_dly[k] <= r_dly[k-1];
        r_data_out <= w_sat_data;
        r_sat      <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign out_sat   = r_sat;

endmodule
